// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generator and load-use hazard detector.
// Tracks destination tags of in-flight instructions so the operand-mux selects are registered for EX.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // Producer tags for the instructions currently in EX and MEM.
  // The WB-stage tag is not kept: a producer that has reached WB retires into a
  // write-before-read register file, so no later consumer ever needs its tag.
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
  logic                  ex_reg_write, mem_reg_write;
  logic                  ex_mem_read, mem_mem_read;

  logic ex_live, mem_live;
  logic a_hit_ex, a_hit_mem, b_hit_ex, b_hit_mem;
  logic load_use;
  logic issue;
  logic [1:0] a_sel_nxt, b_sel_nxt;

  assign ex_live  = ex_reg_write  && (ex_rd  != '0);
  assign mem_live = mem_reg_write && (mem_rd != '0);

  assign a_hit_ex  = id_use_rs && ex_live  && (ex_rd  == id_rs);
  assign a_hit_mem = id_use_rs && mem_live && (mem_rd == id_rs);
  assign b_hit_ex  = id_use_rt && ex_live  && (ex_rd  == id_rt);
  assign b_hit_mem = id_use_rt && mem_live && (mem_rd == id_rt);

  // A load in EX cannot supply its data until it reaches MEM, so the consumer waits one cycle.
  assign load_use = id_valid && ex_mem_read && (a_hit_ex || b_hit_ex);
  assign stall    = load_use && !flush;
  assign issue    = id_valid && !stall && !flush;

  always_comb begin
    a_sel_nxt = SEL_RF;
    b_sel_nxt = SEL_RF;
    if (issue) begin
      if (a_hit_ex)       a_sel_nxt = SEL_MEM;
      else if (a_hit_mem) a_sel_nxt = SEL_WB;
      if (b_hit_ex)       b_sel_nxt = SEL_MEM;
      else if (b_hit_mem) b_sel_nxt = SEL_WB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      fwd_a_sel     <= SEL_RF;
      fwd_b_sel     <= SEL_RF;
      stall_count   <= '0;
    end else begin
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      if (issue) begin
        ex_rd        <= id_rd;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
      end else begin
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end
      fwd_a_sel <= a_sel_nxt;
      fwd_b_sel <= b_sel_nxt;
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: expected selects are queued at issue and popped after the edge.
module tb_fwd_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic          flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall;
  logic [CW-1:0] stall_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  int exp_cnt;

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs, input logic urs,
                       input logic [AW-1:0] rt, input logic urt,
                       input logic [AW-1:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  // Drive one ID instruction, check the combinational stall, then check selects after the edge.
  task automatic issue(input string tag, input logic v, input logic [AW-1:0] rs, input logic urs,
                       input logic [AW-1:0] rt, input logic urt, input logic [AW-1:0] rd,
                       input logic rw, input logic mr, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es);
    logic [3:0] exp;
    drive(v, rs, urs, rt, urt, rd, rw, mr, fl);
    #1;
    chk({tag, "_stall"}, 32'(stall), 32'(es));
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'(0), 32'(1));
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_a"}, 32'(fwd_a_sel), 32'(exp[3:2]));
      chk({tag, "_b"}, 32'(fwd_b_sel), 32'(exp[1:0]));
    end
  endtask

  initial begin
    // reset with a busy, random ID stage
    rst = 1'b1;
    drive(1'b1, AW'($urandom_range(0, 31)), 1'b1, AW'($urandom_range(0, 31)), 1'b1,
          AW'($urandom_range(0, 31)), 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_b", 32'(fwd_b_sel), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    rst = 1'b0;
    issue("idle0", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("idle1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // EX-to-EX: add r3 ; sub r6 = r3 - r4
    issue("exex_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("exex_sub", 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);

    // MEM-to-EX: add r5 ; unrelated r8 ; or r12 = r11 | r5
    issue("memex_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("memex_unr", 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("memex_or", 1'b1, 5'd11, 1'b1, 5'd5, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);

    // priority: r5 written by both EX and MEM producers, newest wins
    issue("prio_p1", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("prio_p2", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("prio_use", 1'b1, 5'd13, 1'b1, 5'd5, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);

    // load-use: lw r7 ; add r15 = r7 + r2 stalls once then forwards from WB
    issue("lu_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("lu_stall", 1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    chk("lu_cnt1", 32'(stall_count), 32'd1);
    issue("lu_go", 1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
    chk("lu_cnt2", 32'(stall_count), 32'd1);

    // register 0 never forwards and never stalls
    issue("r0_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("r0_sub", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("r0_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("r0_use", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    chk("r0_cnt", 32'(stall_count), 32'd1);

    // flush beats stall; the flushed load r2 must not reach EX
    issue("fl_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    issue("fl_kill", 1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    chk("fl_cnt", 32'(stall_count), 32'd1);
    issue("fl_next", 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

    // repeated load-use pairs drive the counter into saturation
    exp_cnt = 1;
    for (int i = 0; i < 16; i++) begin
      issue("sat_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
      issue("sat_stall", 1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd22, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      issue("sat_go", 1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd22, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
      if (exp_cnt < 15) exp_cnt++;
      chk("sat_cnt", 32'(stall_count), 32'(exp_cnt));
    end

    // reset in the middle of a load-use stall
    issue("mr_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd22, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mr_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_stall", 32'(stall), 32'd0);
    chk("mr_cnt", 32'(stall_count), 32'd0);
    chk("mr_a", 32'(fwd_a_sel), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_post_stall", 32'(stall), 32'd0);
    issue("mr_after", 1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd22, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    chk("mr_cnt_after", 32'(stall_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
